mem_stage_wb: RTL and testbench

- Memory-stage controller of the 5-stage MIPS pipeline. It consumes the EX/MEM register outputs (ZeroM, rtdM, ALUOutM, DMdInM, RFWEM, MtoRFSelM, DMWEM, BranchM, JumpM).
- It runs loads and stores over a req/ack data-memory handshake and drives StallM to freeze upstream stages while an access is outstanding.
- It resolves branch/jump redirect (PCSrcM) and owns the MEM/WB pipeline register that feeds writeback.

---
 rtl/mem_stage_wb.sv | 223 ++++++++++++++++++++++
 tb/tb_mem_stage_wb.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_wb.sv
// mem_stage_wb -- memory stage of the 5-stage MIPS pipeline.
//
// Purpose:
//   Takes the EX/MEM register contents and runs loads/stores over a
//   req/ack data-memory handshake. StallM freezes the upstream stages
//   while an access is outstanding. PCSrcM selects the branch/jump target
//   when a taken branch or jump leaves MEM. The module owns the MEM/WB
//   pipeline register that feeds writeback.
//
// Optional build macro:
//   MEM_TIMEOUT_EN -- abort an access after TIMEOUT cycles in WAIT without
//                     DMAck. The instruction is squashed and the sticky
//                     DMErr flag is set. When undefined, WAIT holds until
//                     DMAck, no counter is built, and DMErr is tied low.
//
// Parameters:
//   TIMEOUT : max WAIT cycles without DMAck (MEM_TIMEOUT_EN only)
//   CNT_W   : timeout counter width, 2**CNT_W > TIMEOUT
//
// Ports:
//   CLK, RSTn                        clock (rising edge), synchronous active-low reset
//   ZeroM, rtdM, ALUOutM, DMdInM,
//   RFWEM, MtoRFSelM, DMWEM,
//   BranchM, JumpM                   EX/MEM register outputs
//   DMReq, DMWe, DMAddr, DMWData     registered memory request
//   DMRData, DMAck                   memory response (DMAck is a 1-cycle pulse)
//   StallM, PCSrcM                   combinational pipeline control
//   DMErr                            sticky timeout error
//   RFWEW, MtoRFSelW, rtdW,
//   ALUOutW, DMdOutW                 MEM/WB register outputs
module mem_stage_wb #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        ZeroM,
    input  logic [4:0]  rtdM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] DMdInM,
    input  logic        RFWEM,
    input  logic        MtoRFSelM,
    input  logic        DMWEM,
    input  logic        BranchM,
    input  logic        JumpM,
    output logic        DMReq,
    output logic        DMWe,
    output logic [31:0] DMAddr,
    output logic [31:0] DMWData,
    input  logic [31:0] DMRData,
    input  logic        DMAck,
    output logic        StallM,
    output logic        PCSrcM,
    output logic        DMErr,
    output logic        RFWEW,
    output logic        MtoRFSelW,
    output logic [4:0]  rtdW,
    output logic [31:0] ALUOutW,
    output logic [31:0] DMdOutW
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t      state_reg, state_next;

    logic        dm_req_reg,   dm_req_next;
    logic        dm_we_reg,    dm_we_next;
    logic [31:0] dm_addr_reg,  dm_addr_next;
    logic [31:0] dm_wdata_reg, dm_wdata_next;

    logic        rfwe_w_reg,   rfwe_w_next;
    logic        mtorf_w_reg,  mtorf_w_next;
    logic [4:0]  rtd_w_reg,    rtd_w_next;
    logic [31:0] aluout_w_reg, aluout_w_next;
    logic [31:0] dmdout_w_reg, dmdout_w_next;

    logic        acc;

`ifdef MEM_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             err_reg, err_next;
    logic             timeout_hit;

    // Last permitted WAIT cycle without an ack: the access is abandoned here.
    assign timeout_hit = (state_reg == ST_WAIT) && !DMAck &&
                         (cnt_reg == CNT_W'(TIMEOUT - 1));
    assign DMErr       = err_reg;
`else
    // Parameters only matter for the timeout build.
    logic unused_params;
    assign unused_params = (TIMEOUT > 0) ^ (CNT_W > 0);
    assign DMErr         = 1'b0;
`endif

    // Any instruction that needs the data memory.
    assign acc = MtoRFSelM | DMWEM;

    // The redirect is held off until the instruction actually leaves MEM.
    assign PCSrcM = ((BranchM & ZeroM) | JumpM) & ~StallM;

    always_comb begin
        state_next    = state_reg;
        dm_req_next   = dm_req_reg;
        dm_we_next    = dm_we_reg;
        dm_addr_next  = dm_addr_reg;
        dm_wdata_next = dm_wdata_reg;
        rfwe_w_next   = rfwe_w_reg;
        mtorf_w_next  = mtorf_w_reg;
        rtd_w_next    = rtd_w_reg;
        aluout_w_next = aluout_w_reg;
        dmdout_w_next = dmdout_w_reg;
        StallM        = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_next      = cnt_reg;
        err_next      = err_reg;
`endif

        case (state_reg)
            ST_IDLE: begin
                if (acc) begin
                    // Launch the access; writeback sees a bubble meanwhile.
                    StallM        = 1'b1;
                    state_next    = ST_WAIT;
                    dm_req_next   = 1'b1;
                    dm_we_next    = DMWEM;
                    dm_addr_next  = ALUOutM;
                    dm_wdata_next = DMdInM;
                    rfwe_w_next   = 1'b0;
`ifdef MEM_TIMEOUT_EN
                    cnt_next      = '0;
`endif
                end else begin
                    // Non-memory instruction retires in one cycle; load data
                    // slot keeps its last value.
                    rfwe_w_next   = RFWEM;
                    mtorf_w_next  = MtoRFSelM;
                    rtd_w_next    = rtdM;
                    aluout_w_next = ALUOutM;
                end
            end

            ST_WAIT: begin
                if (DMAck) begin
                    state_next    = ST_IDLE;
                    dm_req_next   = 1'b0;
                    dm_we_next    = 1'b0;
                    rfwe_w_next   = RFWEM;
                    mtorf_w_next  = MtoRFSelM;
                    rtd_w_next    = rtdM;
                    aluout_w_next = ALUOutM;
                    if (MtoRFSelM) begin
                        dmdout_w_next = DMRData;
                    end
                end
`ifdef MEM_TIMEOUT_EN
                else if (timeout_hit) begin
                    // Give up: release the pipeline and squash the writeback.
                    state_next  = ST_IDLE;
                    dm_req_next = 1'b0;
                    dm_we_next  = 1'b0;
                    rfwe_w_next = 1'b0;
                    err_next    = 1'b1;
                end
`endif
                else begin
                    StallM      = 1'b1;
                    rfwe_w_next = 1'b0;
`ifdef MEM_TIMEOUT_EN
                    cnt_next    = cnt_reg + CNT_W'(1);
`endif
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_reg    <= ST_IDLE;
            dm_req_reg   <= 1'b0;
            dm_we_reg    <= 1'b0;
            dm_addr_reg  <= '0;
            dm_wdata_reg <= '0;
            rfwe_w_reg   <= 1'b0;
            mtorf_w_reg  <= 1'b0;
            rtd_w_reg    <= '0;
            aluout_w_reg <= '0;
            dmdout_w_reg <= '0;
`ifdef MEM_TIMEOUT_EN
            cnt_reg      <= '0;
            err_reg      <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            dm_req_reg   <= dm_req_next;
            dm_we_reg    <= dm_we_next;
            dm_addr_reg  <= dm_addr_next;
            dm_wdata_reg <= dm_wdata_next;
            rfwe_w_reg   <= rfwe_w_next;
            mtorf_w_reg  <= mtorf_w_next;
            rtd_w_reg    <= rtd_w_next;
            aluout_w_reg <= aluout_w_next;
            dmdout_w_reg <= dmdout_w_next;
`ifdef MEM_TIMEOUT_EN
            cnt_reg      <= cnt_next;
            err_reg      <= err_next;
`endif
        end
    end

    assign DMReq     = dm_req_reg;
    assign DMWe      = dm_we_reg;
    assign DMAddr    = dm_addr_reg;
    assign DMWData   = dm_wdata_reg;
    assign RFWEW     = rfwe_w_reg;
    assign MtoRFSelW = mtorf_w_reg;
    assign rtdW      = rtd_w_reg;
    assign ALUOutW   = aluout_w_reg;
    assign DMdOutW   = dmdout_w_reg;

endmodule

// File: tb/tb_mem_stage_wb.sv
// Testbench for mem_stage_wb.
// Directed vectors drive the EX/MEM inputs and push each expected writeback
// into a queue; a negedge monitor pops and compares every cycle in which
// RFWEW is high. Handshake and pipeline-control outputs are checked inline
// at the negedge of each cycle.
module tb_mem_stage_wb;

    localparam int TMO = 4;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        ZeroM;
    logic [4:0]  rtdM;
    logic [31:0] ALUOutM;
    logic [31:0] DMdInM;
    logic        RFWEM;
    logic        MtoRFSelM;
    logic        DMWEM;
    logic        BranchM;
    logic        JumpM;
    logic        DMReq;
    logic        DMWe;
    logic [31:0] DMAddr;
    logic [31:0] DMWData;
    logic [31:0] DMRData;
    logic        DMAck;
    logic        StallM;
    logic        PCSrcM;
    logic        DMErr;
    logic        RFWEW;
    logic        MtoRFSelW;
    logic [4:0]  rtdW;
    logic [31:0] ALUOutW;
    logic [31:0] DMdOutW;

    always #5 CLK = ~CLK;

    mem_stage_wb #(.TIMEOUT(TMO), .CNT_W(3)) dut (
        .CLK(CLK), .RSTn(RSTn), .ZeroM(ZeroM), .rtdM(rtdM), .ALUOutM(ALUOutM),
        .DMdInM(DMdInM), .RFWEM(RFWEM), .MtoRFSelM(MtoRFSelM), .DMWEM(DMWEM),
        .BranchM(BranchM), .JumpM(JumpM), .DMReq(DMReq), .DMWe(DMWe),
        .DMAddr(DMAddr), .DMWData(DMWData), .DMRData(DMRData), .DMAck(DMAck),
        .StallM(StallM), .PCSrcM(PCSrcM), .DMErr(DMErr), .RFWEW(RFWEW),
        .MtoRFSelW(MtoRFSelW), .rtdW(rtdW), .ALUOutW(ALUOutW), .DMdOutW(DMdOutW)
    );

    typedef struct packed {
        logic [4:0]  rtd;
        logic [31:0] alu;
        logic        msel;
        logic [31:0] dmd;
    } wb_t;

    wb_t         exp_q[$];
    wb_t         mon_e;
    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_dmd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic nop();
        ZeroM = 0; rtdM = 0; ALUOutM = 0; DMdInM = 0;
        RFWEM = 0; MtoRFSelM = 0; DMWEM = 0; BranchM = 0; JumpM = 0;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic mid();
        @(negedge CLK);
    endtask

    task automatic push_wb(input logic [4:0] rtd, input logic [31:0] alu, input logic msel);
        exp_q.push_back('{rtd: rtd, alu: alu, msel: msel, dmd: exp_dmd});
    endtask

    // Writeback monitor: one line per retired instruction.
    always @(negedge CLK) begin
        if (RFWEW === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL wb_unexpected: got rtdW=%0d ALUOutW=%h want no writeback", rtdW, ALUOutW);
            end else begin
                mon_e = exp_q.pop_front();
                $display("wb rtd=%0d alu=%h msel=%0d dmd=%h", rtdW, ALUOutW, MtoRFSelW, DMdOutW);
                chk("wb_rtdW", 32'(rtdW), 32'(mon_e.rtd));
                chk("wb_ALUOutW", ALUOutW, mon_e.alu);
                chk("wb_MtoRFSelW", 32'(MtoRFSelW), 32'(mon_e.msel));
                chk("wb_DMdOutW", DMdOutW, mon_e.dmd);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with random inputs.
        RSTn = 0;
        ZeroM = 1'($urandom); rtdM = 5'($urandom); ALUOutM = $urandom; DMdInM = $urandom;
        RFWEM = 1'($urandom); MtoRFSelM = 1'($urandom); DMWEM = 1'($urandom);
        BranchM = 1'($urandom); JumpM = 1'($urandom);
        DMRData = $urandom; DMAck = 1'($urandom);
        exp_dmd = 0;
        step(); step();
        nop(); DMAck = 0; DMRData = 0;
        mid();
        chk("rst_DMReq", 32'(DMReq), 0);
        chk("rst_DMWe", 32'(DMWe), 0);
        chk("rst_DMAddr", DMAddr, 0);
        chk("rst_DMWData", DMWData, 0);
        chk("rst_DMErr", 32'(DMErr), 0);
        chk("rst_RFWEW", 32'(RFWEW), 0);
        chk("rst_MtoRFSelW", 32'(MtoRFSelW), 0);
        chk("rst_rtdW", 32'(rtdW), 0);
        chk("rst_ALUOutW", ALUOutW, 0);
        chk("rst_DMdOutW", DMdOutW, 0);
        chk("rst_StallM", 32'(StallM), 0);
        step();
        RSTn = 1;

        // Two ALU ops back to back.
        RFWEM = 1; rtdM = 9; ALUOutM = 32'h0000_00A5;
        push_wb(5'd9, 32'h0000_00A5, 1'b0);
        mid(); chk("alu_StallM", 32'(StallM), 0);
        step();
        RFWEM = 1; rtdM = 7; ALUOutM = 32'h0000_0055;
        push_wb(5'd7, 32'h0000_0055, 1'b0);
        mid(); chk("alu2_StallM", 32'(StallM), 0);
        step();

        // Load, ack on 3rd WAIT cycle; jump flag must be masked while stalled.
        nop(); RFWEM = 1; MtoRFSelM = 1; rtdM = 3; ALUOutM = 32'h100; JumpM = 1;
        DMRData = 32'h0BAD_0BAD;
        mid();
        chk("ld_idle_StallM", 32'(StallM), 1);
        chk("ld_idle_PCSrcM", 32'(PCSrcM), 0);
        chk("ld_idle_DMReq", 32'(DMReq), 0);
        for (int i = 0; i < 2; i++) begin
            step(); mid();
            chk("ld_wait_StallM", 32'(StallM), 1);
            chk("ld_wait_DMReq", 32'(DMReq), 1);
            chk("ld_wait_DMAddr", DMAddr, 32'h100);
            chk("ld_wait_DMWe", 32'(DMWe), 0);
            chk("ld_wait_PCSrcM", 32'(PCSrcM), 0);
        end
        step();
        DMAck = 1; DMRData = 32'hDEAD_BEEF;
        exp_dmd = 32'hDEAD_BEEF;
        push_wb(5'd3, 32'h100, 1'b1);
        mid();
        chk("ld_ack_StallM", 32'(StallM), 0);
        chk("ld_ack_PCSrcM", 32'(PCSrcM), 1);
        chk("ld_ack_DMAddr", DMAddr, 32'h100);
        chk("ld_ack_DMWe", 32'(DMWe), 0);
        step();
        nop(); DMAck = 0; DMRData = 0;
        mid();
        chk("ld_done_DMReq", 32'(DMReq), 0);
        chk("ld_done_RFWEW", 32'(RFWEW), 1);
        chk("ld_done_DMdOutW", DMdOutW, 32'hDEAD_BEEF);
        chk("ld_done_PCSrcM", 32'(PCSrcM), 0);
        step();

        // Store with immediate ack, then taken branch, then untaken branch.
        DMWEM = 1; ALUOutM = 32'h40; DMdInM = 32'h1234;
        mid();
        chk("st_idle_StallM", 32'(StallM), 1);
        step();
        DMAck = 1;
        mid();
        chk("st_wait_DMReq", 32'(DMReq), 1);
        chk("st_wait_DMWe", 32'(DMWe), 1);
        chk("st_wait_DMWData", DMWData, 32'h1234);
        chk("st_wait_DMAddr", DMAddr, 32'h40);
        chk("st_ack_StallM", 32'(StallM), 0);
        chk("st_ack_PCSrcM", 32'(PCSrcM), 0);
        step();
        nop(); DMAck = 0; BranchM = 1; ZeroM = 1;
        mid();
        chk("br_PCSrcM", 32'(PCSrcM), 1);
        chk("br_StallM", 32'(StallM), 0);
        chk("br_DMReq", 32'(DMReq), 0);
        chk("br_DMWe", 32'(DMWe), 0);
        step();
        nop(); BranchM = 1; ZeroM = 0;
        mid();
        chk("br_nt_PCSrcM", 32'(PCSrcM), 0);
        step();

        // Back-to-back loads with immediate acks.
        nop(); RFWEM = 1; MtoRFSelM = 1; rtdM = 4; ALUOutM = 32'h8;
        mid(); chk("b2b_a_StallM", 32'(StallM), 1);
        step();
        DMAck = 1; DMRData = 32'h1111_1111;
        exp_dmd = 32'h1111_1111;
        push_wb(5'd4, 32'h8, 1'b1);
        mid(); chk("b2b_a_ack_StallM", 32'(StallM), 0);
        step();
        nop(); RFWEM = 1; MtoRFSelM = 1; rtdM = 5; ALUOutM = 32'hC; DMAck = 0;
        mid();
        chk("b2b_b_StallM", 32'(StallM), 1);
        chk("b2b_b_DMReq", 32'(DMReq), 0);
        step();
        DMAck = 1; DMRData = 32'h2222_2222;
        exp_dmd = 32'h2222_2222;
        push_wb(5'd5, 32'hC, 1'b1);
        mid(); chk("b2b_b_DMAddr", DMAddr, 32'hC);
        step();
        nop(); DMAck = 0; DMRData = 0;
        mid();
        step();

        // Reset while in WAIT; a late ack must be ignored.
        RFWEM = 1; MtoRFSelM = 1; rtdM = 12; ALUOutM = 32'h200;
        mid(); chk("rw_idle_StallM", 32'(StallM), 1);
        step();
        mid(); chk("rw_wait_DMReq", 32'(DMReq), 1);
        step();
        RSTn = 0; nop();
        step();
        RSTn = 1; DMAck = 1; DMRData = 32'hCAFE_F00D;
        exp_dmd = 0;
        mid();
        chk("rw_DMReq", 32'(DMReq), 0);
        chk("rw_StallM", 32'(StallM), 0);
        step();
        DMAck = 0; DMRData = 0;
        mid();
        chk("rw_DMdOutW", DMdOutW, 0);
        chk("rw_RFWEW", 32'(RFWEW), 0);
        chk("rw_DMReq_late", 32'(DMReq), 0);
        step();

        // Load that is never acknowledged (timeout build) or is held long.
        RFWEM = 1; MtoRFSelM = 1; rtdM = 13; ALUOutM = 32'h300;
        mid(); chk("to_idle_StallM", 32'(StallM), 1);
`ifdef MEM_TIMEOUT_EN
        for (int w = 1; w <= TMO; w++) begin
            step(); mid();
            chk("to_wait_DMReq", 32'(DMReq), 1);
            chk("to_wait_StallM", 32'(StallM), (w < TMO) ? 32'd1 : 32'd0);
        end
        step();
        nop();
        mid();
        chk("to_DMReq", 32'(DMReq), 0);
        chk("to_DMErr", 32'(DMErr), 1);
        chk("to_RFWEW", 32'(RFWEW), 0);
        chk("to_StallM", 32'(StallM), 0);
        step(); step();
        mid();
        chk("to_DMErr_sticky", 32'(DMErr), 1);
        step();
`else
        for (int w = 1; w <= 20; w++) begin
            step(); mid();
            chk("hold_StallM", 32'(StallM), 1);
            chk("hold_DMReq", 32'(DMReq), 1);
        end
        chk("hold_DMErr", 32'(DMErr), 0);
        step();
        DMAck = 1; DMRData = 32'h3333_3333;
        exp_dmd = 32'h3333_3333;
        push_wb(5'd13, 32'h300, 1'b1);
        mid(); chk("hold_ack_StallM", 32'(StallM), 0);
        step();
        nop(); DMAck = 0; DMRData = 0;
        mid(); chk("hold_DMErr_after", 32'(DMErr), 0);
        step();
`endif

        // ALU op after loads: DMdOutW must keep the last load value.
        RFWEM = 1; rtdM = 20; ALUOutM = 32'h77;
        push_wb(5'd20, 32'h77, 1'b0);
        mid();
        step();
        nop();
        mid();
        step(); step();
        chk("queue_drained", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
